e203_rst_seq: RTL and testbench



---
 rtl/e203_rst_seq.sv | 180 ++++++++++++++++++
 tb/tb_e203_rst_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/e203_rst_seq.sv
// e203_rst_seq
// -----------------------------------------------------------------------------
// Reset sequencer for the FPGA system top (clk_16M domain).
//
// Synchronizes the raw PLL locked flag and the raw MCU reset button, debounces
// the button and walks a four-state sequence:
//   HOLD       -> both resets asserted for at least MIN_ASSERT cycles
//   WAIT_LOCK  -> both resets asserted until LOCK_STABLE consecutive locked cycles
//   REL_PERIPH -> peripheral reset released, core held for PERIPH_TO_CORE cycles
//   RUN        -> both resets released
// Lock loss (REL_PERIPH/RUN) or a debounced button press (any state but HOLD)
// returns to HOLD and records the cause and a saturating entry count.
//
// Ports:
//   clk         in   16 MHz system clock
//   resetn      in   synchronous active-low reset
//   pll_locked  in   raw MMCM locked flag (asynchronous)
//   btn_rst     in   raw reset button, pressed = 1 (asynchronous)
//   periph_rst  out  peripheral reset, active-high (registered)
//   core_rst_n  out  SoC external reset, active-low (registered)
//   seq_state   out  current state: 0 HOLD, 1 WAIT_LOCK, 2 REL_PERIPH, 3 RUN
//   rst_cause   out  cause of last HOLD entry: 00 power-on, 01 button, 10 lock loss
//   rst_count   out  HOLD entries since resetn, saturating at 255
//
// Handshake: none; all inputs are level signals and all outputs are registered,
// so there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module e203_rst_seq #(
    parameter int MIN_ASSERT     = 16,
    parameter int LOCK_STABLE    = 256,
    parameter int PERIPH_TO_CORE = 64,
    parameter int DEBOUNCE       = 16000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_locked,
    input  logic       btn_rst,
    output logic       periph_rst,
    output logic       core_rst_n,
    output logic [1:0] seq_state,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_count
);

    typedef enum logic [1:0] {
        S_HOLD       = 2'd0,
        S_WAIT_LOCK  = 2'd1,
        S_REL_PERIPH = 2'd2,
        S_RUN        = 2'd3
    } state_t;

    // Terminal counts: a phase of N cycles ends when the counter shows N-1.
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] P2C_LAST  = CNT_W'(PERIPH_TO_CORE - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE - 1);

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] db_cnt;

    logic lock_s1, lock_s;
    logic btn_s1, btn_s;
    logic btn_db, btn_db_d;

    logic lock_loss;
    logic btn_abort;

    // Two-flop synchronizers for both asynchronous inputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
            btn_s1  <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            lock_s1 <= pll_locked;
            lock_s  <= lock_s1;
            btn_s1  <= btn_rst;
            btn_s   <= btn_s1;
        end
    end

    // Debounce: btn_db follows btn_s only after DEBOUNCE consecutive cycles of
    // disagreement; any agreeing cycle restarts the count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
        end else begin
            btn_db_d <= btn_db;
            if (btn_s != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= btn_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_ONE;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Lock loss only aborts once the peripheral reset has been released; in
    // WAIT_LOCK a dropped lock just restarts the qualification count.
    assign lock_loss = !lock_s && (state == S_REL_PERIPH || state == S_RUN);
    assign btn_abort = btn_db && !btn_db_d && (state != S_HOLD);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_HOLD;
            phase_cnt  <= '0;
            periph_rst <= 1'b1;
            core_rst_n <= 1'b0;
            rst_cause  <= 2'b00;
            rst_count  <= 8'd0;
        end else if (lock_loss || btn_abort) begin
            // Lock loss takes priority when both happen in the same cycle.
            state      <= S_HOLD;
            phase_cnt  <= '0;
            periph_rst <= 1'b1;
            core_rst_n <= 1'b0;
            rst_cause  <= lock_loss ? 2'b10 : 2'b01;
            if (rst_count != 8'hFF) begin
                rst_count <= rst_count + 8'd1;
            end
        end else begin
            case (state)
                S_HOLD: begin
                    // A held button freezes HOLD; the minimum assertion time
                    // is measured from the debounced release.
                    if (btn_db) begin
                        phase_cnt <= '0;
                    end else if (phase_cnt == HOLD_LAST) begin
                        state     <= S_WAIT_LOCK;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                    end
                end
                S_WAIT_LOCK: begin
                    if (!lock_s) begin
                        phase_cnt <= '0;
                    end else if (phase_cnt == LOCK_LAST) begin
                        state      <= S_REL_PERIPH;
                        phase_cnt  <= '0;
                        periph_rst <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                    end
                end
                S_REL_PERIPH: begin
                    if (phase_cnt == P2C_LAST) begin
                        state      <= S_RUN;
                        phase_cnt  <= '0;
                        core_rst_n <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                    end
                end
                S_RUN: begin
                    phase_cnt <= '0;
                end
                default: begin
                    state      <= S_HOLD;
                    phase_cnt  <= '0;
                    periph_rst <= 1'b1;
                    core_rst_n <= 1'b0;
                end
            endcase
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_e203_rst_seq.sv
// Testbench for e203_rst_seq.
// Time base: T0 is the last edge that samples resetn low; resetn is driven
// high just after it, so edge T0+n is the n-th edge that runs the sequencer.
// Each table row holds its inputs for 'cyc' edges and then checks all outputs
// 1 time unit after the last of those edges.
module tb_e203_rst_seq;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_locked;
    logic       btn_rst;
    logic       periph_rst;
    logic       core_rst_n;
    logic [1:0] seq_state;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        int         cyc;
        logic       rstn;
        logic       lock;
        logic       btn;
        logic       e_periph;
        logic       e_core_n;
        logic [1:0] e_state;
        logic [1:0] e_cause;
        logic [7:0] e_count;
    } vec_t;

    vec_t vecs[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    e203_rst_seq #(
        .MIN_ASSERT    (16),
        .LOCK_STABLE   (256),
        .PERIPH_TO_CORE(64),
        .DEBOUNCE      (8),
        .CNT_W         (16)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pll_locked(pll_locked),
        .btn_rst   (btn_rst),
        .periph_rst(periph_rst),
        .core_rst_n(core_rst_n),
        .seq_state (seq_state),
        .rst_cause (rst_cause),
        .rst_count (rst_count)
    );

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic add(input string name, input int cyc, input logic rstn,
                       input logic lock, input logic btn, input logic e_p,
                       input logic e_c, input logic [1:0] e_s,
                       input logic [1:0] e_cause, input logic [7:0] e_cnt);
        vec_t v;
        v.name = name; v.cyc = cyc; v.rstn = rstn; v.lock = lock; v.btn = btn;
        v.e_periph = e_p; v.e_core_n = e_c; v.e_state = e_s;
        v.e_cause = e_cause; v.e_count = e_cnt;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic e_p, input logic e_c,
                         input logic [1:0] e_s, input logic [1:0] e_cause,
                         input logic [7:0] e_cnt);
        n_vec++;
        if (periph_rst !== e_p || core_rst_n !== e_c || seq_state !== e_s ||
            rst_cause !== e_cause || rst_count !== e_cnt) begin
            n_fail++;
            $display("FAIL %s: got periph=%b core_n=%b state=%0d cause=%b count=%0d, want periph=%b core_n=%b state=%0d cause=%b count=%0d",
                     name, periph_rst, core_rst_n, seq_state, rst_cause, rst_count,
                     e_p, e_c, e_s, e_cause, e_cnt);
        end
    endtask

    task automatic apply(input vec_t v);
        resetn     = v.rstn;
        pll_locked = v.lock;
        btn_rst    = v.btn;
        step(v.cyc);
        check(v.name, v.e_periph, v.e_core_n, v.e_state, v.e_cause, v.e_count);
    endtask

    // ---------------- test ----------------
    int         sat_at;
    logic [7:0] exp_cnt;

    initial begin
        resetn     = 1'b0;
        pll_locked = 1'b1;
        btn_rst    = 1'b0;

        //   name             cyc  rstn lock btn  per cor st cause cnt
        // Power-on: periph falls at T0+272, core rises at T0+336.
        add("reset",           3,  0,   1,   0,   1,  0,  0, 2'b00, 0);
        add("hold_t15",       15,  1,   1,   0,   1,  0,  0, 2'b00, 0);
        add("wait_t16",        1,  1,   1,   0,   1,  0,  1, 2'b00, 0);
        add("wait_t271",     255,  1,   1,   0,   1,  0,  1, 2'b00, 0);
        add("rel_t272",        1,  1,   1,   0,   0,  0,  2, 2'b00, 0);
        add("rel_t335",       63,  1,   1,   0,   0,  0,  2, 2'b00, 0);
        add("run_t336",        1,  1,   1,   0,   0,  1,  3, 2'b00, 0);
        add("run_stay",       20,  1,   1,   0,   0,  1,  3, 2'b00, 0);
        // Lock loss in RUN: HOLD 3 edges after raw lock falls.
        add("lockloss_e2",     2,  1,   0,   0,   0,  1,  3, 2'b00, 0);
        add("lockloss_e3",     1,  1,   0,   0,   1,  0,  0, 2'b10, 1);
        add("nolock_wait",    30,  1,   0,   0,   1,  0,  1, 2'b10, 1);
        // Lock bounce in WAIT_LOCK: low T0+100..105, lock_s back at T0+107,
        // so periph falls at T0+107+256 = T0+363.
        add("rst2",            2,  0,   1,   0,   1,  0,  0, 2'b00, 0);
        add("bounce_t100",   100,  1,   1,   0,   1,  0,  1, 2'b00, 0);
        add("bounce_t105",     5,  1,   0,   0,   1,  0,  1, 2'b00, 0);
        add("bounce_t272",   167,  1,   1,   0,   1,  0,  1, 2'b00, 0);
        add("bounce_t362",    90,  1,   1,   0,   1,  0,  1, 2'b00, 0);
        add("bounce_t363",     1,  1,   1,   0,   0,  0,  2, 2'b00, 0);
        add("bounce_run",     64,  1,   1,   0,   0,  1,  3, 2'b00, 0);
        // Button glitch of 5 cycles (DEBOUNCE=8) is ignored.
        add("glitch_on",       5,  1,   1,   1,   0,  1,  3, 2'b00, 0);
        add("glitch_off",     20,  1,   1,   0,   0,  1,  3, 2'b00, 0);
        // 20-cycle press: HOLD at press+11, then resequence from release R:
        // btn_db low at R+10, WAIT_LOCK at R+26, REL at R+282, RUN at R+346.
        add("press_p10",      10,  1,   1,   1,   0,  1,  3, 2'b00, 0);
        add("press_p11",       1,  1,   1,   1,   1,  0,  0, 2'b01, 1);
        add("press_held",      9,  1,   1,   1,   1,  0,  0, 2'b01, 1);
        add("release_r25",    25,  1,   1,   0,   1,  0,  0, 2'b01, 1);
        add("release_r26",     1,  1,   1,   0,   1,  0,  1, 2'b01, 1);
        add("release_r281",  255,  1,   1,   0,   1,  0,  1, 2'b01, 1);
        add("release_r282",    1,  1,   1,   0,   0,  0,  2, 2'b01, 1);
        add("release_r345",   63,  1,   1,   0,   0,  0,  2, 2'b01, 1);
        add("release_r346",    1,  1,   1,   0,   0,  1,  3, 2'b01, 1);
        // Button rise and lock loss seen on the same FSM edge: lock loss wins.
        add("both_p8",         8,  1,   1,   1,   0,  1,  3, 2'b01, 1);
        add("both_p10",        2,  1,   0,   1,   0,  1,  3, 2'b01, 1);
        add("both_p11",        1,  1,   0,   1,   1,  0,  0, 2'b10, 2);
        add("both_after",      5,  1,   0,   1,   1,  0,  0, 2'b10, 2);
        add("both_rerun",    346,  1,   1,   0,   0,  1,  3, 2'b10, 2);
        sat_at = vecs.size();
        // After saturation: one reset edge, then reset during REL_PERIPH.
        add("sat_reset",       1,  0,   1,   0,   1,  0,  0, 2'b00, 0);
        add("mid_rel_t300",  300,  1,   1,   0,   0,  0,  2, 2'b00, 0);
        add("mid_reset",       1,  0,   1,   0,   1,  0,  0, 2'b00, 0);
        add("mid_t271",      271,  1,   1,   0,   1,  0,  1, 2'b00, 0);
        add("mid_t272",        1,  1,   1,   0,   0,  0,  2, 2'b00, 0);
        add("mid_t335",       63,  1,   1,   0,   0,  0,  2, 2'b00, 0);
        add("mid_t336",        1,  1,   1,   0,   0,  1,  3, 2'b00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == sat_at) begin
                // Saturation: repeated button aborts (12-cycle press, 40-cycle
                // release). Each press is debounced while in WAIT_LOCK, so every
                // iteration is one HOLD entry and ends back in WAIT_LOCK.
                exp_cnt = 8'd2;
                for (int k = 0; k < 260; k++) begin
                    btn_rst = 1'b1;
                    step(12);
                    btn_rst = 1'b0;
                    step(40);
                    if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
                    check($sformatf("sat_iter%0d", k), 1'b1, 1'b0, 2'd1, 2'b01, exp_cnt);
                end
            end
            apply(vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
